// File: rtl/msrh_inst_buffer_if.sv
// Fetch-line / dispatch-group handshake bundle for msrh_inst_buffer.
// master = fetch + decoder side, slave = the instruction buffer.
interface msrh_inst_buffer_if #(
    parameter int FETCH_W   = 4,
    parameter int DISP_SIZE = 2,
    parameter int VADDR_W   = 39
);
    logic                    f2_valid;
    logic [VADDR_W-1:0]      f2_pc;
    logic [32*FETCH_W-1:0]   f2_inst;
    logic                    f2_ready;
    logic                    disp_valid;
    logic [VADDR_W-1:0]      disp_pc;
    logic [32*DISP_SIZE-1:0] disp_inst;
    logic [DISP_SIZE-1:0]    disp_inst_valid;
    logic                    disp_ready;

    modport master (
        output f2_valid, f2_pc, f2_inst, disp_ready,
        input  f2_ready, disp_valid, disp_pc, disp_inst, disp_inst_valid
    );

    modport slave (
        input  f2_valid, f2_pc, f2_inst, disp_ready,
        output f2_ready, disp_valid, disp_pc, disp_inst, disp_inst_valid
    );
endinterface

// File: rtl/msrh_inst_buffer.sv
// Instruction buffer between fetch (F2) and decode: line FIFO, dispatch groups that never cross a line.
// Optional same-cycle bypass of the incoming line when empty: define MSRH_IBUF_BYPASS_EN.
module msrh_inst_buffer #(
    parameter int FETCH_W   = 4,
    parameter int DISP_SIZE = 2,
    parameter int DEPTH     = 4,
    parameter int VADDR_W   = 39
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_flush_valid,
    msrh_inst_buffer_if.slave  bus
);
    localparam int OFF_W  = $clog2(FETCH_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int CNT_W  = OFF_W + 1;
    localparam int BASE_W = VADDR_W - OFF_W - 2;
`ifdef MSRH_IBUF_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    // Line payload and base PC are plain storage; only pointers and offsets are reset.
    logic [32*FETCH_W-1:0] line_mem [DEPTH];
    logic [BASE_W-1:0]     base_mem [DEPTH];
    logic [OFF_W-1:0]      off_q    [DEPTH];
    logic [OFF_W-1:0]      off_d    [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  empty, full;
    logic [OFF_W-1:0]      f2_off;
    logic [BASE_W-1:0]     f2_base;
    logic                  unused_pc_lsb;

    assign wr_idx  = wr_ptr_q[IDX_W-1:0];
    assign rd_idx  = rd_ptr_q[IDX_W-1:0];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign f2_off  = bus.f2_pc[OFF_W+1:2];
    assign f2_base = bus.f2_pc[VADDR_W-1:OFF_W+2];
    assign unused_pc_lsb = ^bus.f2_pc[1:0];

    // Group source: the head entry, or the incoming line when bypassing an empty FIFO.
    logic                  bypass_sel;
    logic                  src_valid;
    logic [32*FETCH_W-1:0] src_line;
    logic [BASE_W-1:0]     src_base;
    logic [OFF_W-1:0]      src_off;
    logic [CNT_W-1:0]      room, n;
    logic                  line_done;

    always_comb begin
        bypass_sel = BYPASS_EN && empty && bus.f2_valid && !i_flush_valid;
        src_valid  = !empty;
        src_line   = line_mem[rd_idx];
        src_base   = base_mem[rd_idx];
        src_off    = off_q[rd_idx];
        if (bypass_sel) begin
            src_valid = 1'b1;
            src_line  = bus.f2_inst;
            src_base  = f2_base;
            src_off   = f2_off;
        end
        room      = CNT_W'(FETCH_W) - CNT_W'(src_off);
        n         = (room < CNT_W'(DISP_SIZE)) ? room : CNT_W'(DISP_SIZE);
        line_done = (room == n);
    end

    logic [DISP_SIZE-1:0] slot_vld;

    genvar gi;
    generate
        for (gi = 0; gi < DISP_SIZE; gi++) begin : g_slot
            logic [OFF_W-1:0] idx;
            assign idx          = src_off + OFF_W'(gi);
            assign slot_vld[gi] = src_valid && (CNT_W'(gi) < n);
            assign bus.disp_inst[32*gi +: 32] =
                slot_vld[gi] ? src_line[{idx, 5'b0} +: 32] : 32'h0;
        end
    endgenerate

    assign bus.disp_valid      = src_valid;
    assign bus.disp_inst_valid = slot_vld;
    assign bus.disp_pc         = src_valid ? {src_base, src_off, 2'b00} : '0;
    assign bus.f2_ready        = !full;

    logic             fire;
    logic             write_en;
    logic [OFF_W-1:0] wr_off;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        off_d    = off_q;
        fire     = src_valid && bus.disp_ready;
        write_en = 1'b0;
        wr_off   = f2_off;
        if (i_flush_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            for (int i = 0; i < DEPTH; i++) off_d[i] = '0;
        end else begin
            if (bypass_sel) begin
                // A bypassed line is stored only if the decoder left part of it behind.
                write_en = !(fire && line_done);
                if (fire) wr_off = src_off + n[OFF_W-1:0];
            end else begin
                write_en = bus.f2_valid && !full;
                if (fire) begin
                    if (line_done) rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    else           off_d[rd_idx] = src_off + n[OFF_W-1:0];
                end
            end
            if (write_en) begin
                off_d[wr_idx] = wr_off;
                wr_ptr_d      = wr_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) off_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) off_q[i] <= off_d[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (write_en) begin
            line_mem[wr_idx] <= bus.f2_inst;
            base_mem[wr_idx] <= f2_base;
        end
    end
endmodule

// File: tb/tb_msrh_inst_buffer.sv
// Scoreboard bench for msrh_inst_buffer: directed lines in, expected dispatch groups queued, monitor compares.
module tb_msrh_inst_buffer;
    typedef struct packed {
        logic [38:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } grp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_grp = 0;
    grp_t exp_q[$];

    msrh_inst_buffer_if #(.FETCH_W(4), .DISP_SIZE(2), .VADDR_W(39)) bus ();

    msrh_inst_buffer #(.FETCH_W(4), .DISP_SIZE(2), .DEPTH(4), .VADDR_W(39)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_flush_valid (flush),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted group must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && bus.disp_valid && bus.disp_ready) begin
            grp_t got;
            got.pc   = bus.disp_pc;
            got.inst = bus.disp_inst;
            got.mask = bus.disp_inst_valid;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL grp%0d unexpected: got pc=%h inst=%h mask=%b, required none",
                         n_grp, got.pc, got.inst, got.mask);
            end else begin
                grp_t e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL grp%0d: got pc=%h inst=%h mask=%b, required pc=%h inst=%h mask=%b",
                             n_grp, got.pc, got.inst, got.mask, e.pc, e.inst, e.mask);
                end else begin
                    $display("grp%0d ok pc=%h inst=%h mask=%b", n_grp, got.pc, got.inst, got.mask);
                end
            end
            n_grp++;
        end
    end

    function automatic logic [127:0] make_line(input logic [31:0] tag);
        return {tag + 32'd3, tag + 32'd2, tag + 32'd1, tag};
    endfunction

    task automatic exp(input logic [38:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] mask);
        grp_t g;
        g.pc = pc; g.inst = {i1, i0}; g.mask = mask;
        exp_q.push_back(g);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end else begin
            $display("chk %s ok = %h", name, got);
        end
    endtask

    task automatic push_line(input logic [38:0] pc, input logic [31:0] tag);
        bit ok;
        ok = 1'b0;
        bus.f2_valid = 1'b1;
        bus.f2_pc    = pc;
        bus.f2_inst  = make_line(tag);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.f2_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout pc=%h: got no f2_ready, required acceptance", pc);
        end
        bus.f2_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.disp_valid;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s drain: got %0d groups pending, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        bus.f2_valid = 1'b0; bus.f2_pc = '0; bus.f2_inst = '0; bus.disp_ready = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_disp_valid", 64'(bus.disp_valid), 64'd0);
        chk("rst_inst_valid", 64'(bus.disp_inst_valid), 64'd0);
        chk("rst_inst", bus.disp_inst, 64'd0);
        chk("rst_pc", 64'(bus.disp_pc), 64'd0);
        chk("rst_f2_ready", 64'(bus.f2_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned line, two full groups
        bus.disp_ready = 1'b1;
        exp(39'h1000, 32'hA000_0000, 32'hA000_0001, 2'b11);
        exp(39'h1008, 32'hA000_0002, 32'hA000_0003, 2'b11);
        push_line(39'h1000, 32'hA000_0000);
        wait_drain("t1");
        @(negedge clk);
        chk("t1_empty_valid", 64'(bus.disp_valid), 64'd0);
        chk("t1_empty_pc", 64'(bus.disp_pc), 64'd0);
        @(posedge clk); #1;

        // Offset 3: single-slot group
        exp(39'h100C, 32'hB000_0003, 32'h0, 2'b01);
        push_line(39'h100C, 32'hB000_0000);
        // Offset 1: two-slot group then tail single
        exp(39'h1014, 32'hC000_0001, 32'hC000_0002, 2'b11);
        exp(39'h101C, 32'hC000_0003, 32'h0, 2'b01);
        push_line(39'h1014, 32'hC000_0000);
        wait_drain("t2");

        // Fill with decoder stalled, hold off a fifth line
        bus.disp_ready = 1'b0;
        exp(39'h3000, 32'hD100_0000, 32'hD100_0001, 2'b11);
        exp(39'h3008, 32'hD100_0002, 32'hD100_0003, 2'b11);
        exp(39'h3010, 32'hD200_0000, 32'hD200_0001, 2'b11);
        exp(39'h3018, 32'hD200_0002, 32'hD200_0003, 2'b11);
        exp(39'h3028, 32'hD300_0002, 32'hD300_0003, 2'b11);
        exp(39'h3030, 32'hD400_0000, 32'hD400_0001, 2'b11);
        exp(39'h3038, 32'hD400_0002, 32'hD400_0003, 2'b11);
        exp(39'h3044, 32'hD500_0001, 32'hD500_0002, 2'b11);
        exp(39'h304C, 32'hD500_0003, 32'h0, 2'b01);
        push_line(39'h3000, 32'hD100_0000);
        push_line(39'h3010, 32'hD200_0000);
        push_line(39'h3028, 32'hD300_0000);
        push_line(39'h3030, 32'hD400_0000);
        bus.f2_valid = 1'b1; bus.f2_pc = 39'h3044; bus.f2_inst = make_line(32'hD500_0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_full_ready", 64'(bus.f2_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.disp_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_first_pop", 64'(bus.f2_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_ready_freeing_pop", 64'(bus.f2_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_ready_after_free", 64'(bus.f2_ready), 64'd1);
        @(posedge clk); #1;
        bus.f2_valid = 1'b0;
        wait_drain("t3");

        // Flush with three lines buffered and a same-cycle push
        bus.disp_ready = 1'b0;
        push_line(39'h5000, 32'hE100_0000);
        push_line(39'h5010, 32'hE200_0000);
        push_line(39'h5020, 32'hE300_0000);
        bus.f2_valid = 1'b1; bus.f2_pc = 39'h5030; bus.f2_inst = make_line(32'hE400_0000);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.f2_valid = 1'b0;
        @(negedge clk);
        chk("t5_flush_valid", 64'(bus.disp_valid), 64'd0);
        chk("t5_flush_ready", 64'(bus.f2_ready), 64'd1);
        @(posedge clk); #1;
        bus.disp_ready = 1'b1;
        exp(39'h6008, 32'hF000_0002, 32'hF000_0003, 2'b11);
        push_line(39'h6008, 32'hF000_0000);
        wait_drain("t5");

        // Asynchronous reset while a line is held
        bus.disp_ready = 1'b0;
        push_line(39'h7000, 32'h7700_0000);
        @(negedge clk);
        chk("ar_pre_valid", 64'(bus.disp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.disp_valid), 64'd0);
        chk("ar_inst_valid", 64'(bus.disp_inst_valid), 64'd0);
        chk("ar_inst", bus.disp_inst, 64'd0);
        chk("ar_pc", 64'(bus.disp_pc), 64'd0);
        chk("ar_ready", 64'(bus.f2_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_after_valid", 64'(bus.disp_valid), 64'd0);
        @(posedge clk); #1;

`ifdef MSRH_IBUF_BYPASS_EN
        bus.disp_ready = 1'b1;
        exp(39'h2000, 32'h2200_0000, 32'h2200_0001, 2'b11);
        exp(39'h2008, 32'h2200_0002, 32'h2200_0003, 2'b11);
        bus.f2_valid = 1'b1; bus.f2_pc = 39'h2000; bus.f2_inst = make_line(32'h2200_0000);
        @(negedge clk);
        chk("t6_bypass_valid", 64'(bus.disp_valid), 64'd1);
        chk("t6_bypass_pc", 64'(bus.disp_pc), 64'h2000);
        @(posedge clk); #1;
        bus.f2_valid = 1'b0;
        @(negedge clk);
        chk("t6_stored_pc", 64'(bus.disp_pc), 64'h2008);
        @(posedge clk); #1;
        wait_drain("t6");
`endif

        wait_drain("final");
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
